// File: rtl/gobang_pkg.sv
// rtl/gobang_pkg.sv - shared colours, direction encodings, step tables and FSM states for the win scanner
package gobang_pkg;

  // Cell / stone colours
  localparam logic [1:0] C_EMPTY = 2'b00;
  localparam logic [1:0] C_P1    = 2'b01;
  localparam logic [1:0] C_P2    = 2'b10;

  // Scan directions, checked in this order
  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_A} dir_t;

  // Unit steps per direction; the anti-diagonal walks +x,-y
  localparam logic signed [1:0] DX [4] = '{2'sd1, 2'sd0, 2'sd1,  2'sd1};
  localparam logic signed [1:0] DY [4] = '{2'sd0, 2'sd1, 2'sd1, -2'sd1};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COMPARE, S_DONE} state_t;
  typedef enum logic {PH_FWD, PH_BWD} phase_t;

endpackage

// File: rtl/win_step_gen.sv
// rtl/win_step_gen.sv - next-cell coordinate, bounds check and board address for one scan step
module win_step_gen
  import gobang_pkg::*;
#(
  parameter int BOARD_W = 15,
  parameter int BOARD_H = 15,
  parameter int ADDR_W  = $clog2(BOARD_W * BOARD_H),
  parameter int XW      = $clog2(BOARD_W),
  parameter int YW      = $clog2(BOARD_H)
) (
  input  logic [XW-1:0]     cur_x,
  input  logic [YW-1:0]     cur_y,
  input  logic [1:0]        dir,
  input  logic              bwd,
  output logic [XW-1:0]     nxt_x,
  output logic [YW-1:0]     nxt_y,
  output logic              in_bounds,
  output logic [ADDR_W-1:0] addr
);

  // One sign bit beyond what BOARD_W/BOARD_H need, so -1 and W/H are both representable
  localparam int SXW = $clog2(BOARD_W + 1) + 1;
  localparam int SYW = $clog2(BOARD_H + 1) + 1;
  localparam logic signed [SXW-1:0] LIM_X = SXW'(BOARD_W);
  localparam logic signed [SYW-1:0] LIM_Y = SYW'(BOARD_H);
  localparam logic [ADDR_W-1:0]     ROW_A = ADDR_W'(BOARD_W);

  logic signed [1:0]     dx, dy;
  logic signed [SXW-1:0] sx, px;
  logic signed [SYW-1:0] sy, py;

  // Step the cursor (negated on the backward phase) and flag anything off the board
  always_comb begin
    dx = DX[dir];
    dy = DY[dir];
    sx = {{(SXW-2){dx[1]}}, dx};
    sy = {{(SYW-2){dy[1]}}, dy};
    if (bwd) begin
      sx = -sx;
      sy = -sy;
    end
    px = $signed({{(SXW-XW){1'b0}}, cur_x}) + sx;
    py = $signed({{(SYW-YW){1'b0}}, cur_y}) + sy;
    in_bounds = !px[SXW-1] && (px < LIM_X) && !py[SYW-1] && (py < LIM_Y);
    nxt_x = px[XW-1:0];
    nxt_y = py[YW-1:0];
    addr  = ADDR_W'(nxt_y) * ROW_A + ADDR_W'(nxt_x);
  end

endmodule

// File: rtl/win_scanner.sv
// rtl/win_scanner.sv - sequential line-of-WIN_LEN detector around the last move; RENJU_EXACT_EN selects the exact-length rule
module win_scanner
  import gobang_pkg::*;
#(
  parameter int BOARD_W = 15,
  parameter int BOARD_H = 15,
  parameter int WIN_LEN = 5,
  parameter int ADDR_W  = $clog2(BOARD_W * BOARD_H)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [$clog2(BOARD_W)-1:0] move_x,
  input  logic [$clog2(BOARD_H)-1:0] move_y,
  input  logic [1:0]                 move_color,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          rd_addr,
  input  logic [1:0]                 rd_data,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 winner,
  output logic [1:0]                 win_dir
);

  localparam int XW = $clog2(BOARD_W);
  localparam int YW = $clog2(BOARD_H);
  localparam int CW = $clog2(WIN_LEN + 2);
`ifdef RENJU_EXACT_EN
  localparam logic [CW-1:0] STOP_C = CW'(WIN_LEN + 1);
`else
  localparam logic [CW-1:0] STOP_C = CW'(WIN_LEN);
`endif
  localparam logic [CW-1:0] WIN_C = CW'(WIN_LEN);

  state_t          state;
  phase_t          phase;
  dir_t            dir;
  logic [XW-1:0]   mx, cx, nx;
  logic [YW-1:0]   my, cy, ny;
  logic [1:0]      color;
  logic [CW-1:0]   count, cnt_nxt, ev_cnt;
  logic            inb, match, end_ph, stop_hit, eval_dir, flip, won;
  logic [ADDR_W-1:0] step_addr;

  win_step_gen #(
    .BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .ADDR_W(ADDR_W), .XW(XW), .YW(YW)
  ) u_step (
    .cur_x(cx), .cur_y(cy), .dir(dir), .bwd(phase == PH_BWD),
    .nxt_x(nx), .nxt_y(ny), .in_bounds(inb), .addr(step_addr)
  );

  // Read strobe is decoded from the ISSUE state so the RAM data lands in COMPARE
  assign rd_en   = (state == S_ISSUE) && inb;
  assign rd_addr = rd_en ? step_addr : '0;

  // Phase-end and direction-evaluation decisions for the current cycle
  always_comb begin
    match    = (rd_data == color);
    cnt_nxt  = count + CW'(1);
    ev_cnt   = (state == S_COMPARE && match) ? cnt_nxt : count;
    end_ph   = (state == S_ISSUE && !inb) || (state == S_COMPARE && !match);
    stop_hit = (state == S_COMPARE) && match && (cnt_nxt == STOP_C);
    eval_dir = (end_ph && phase == PH_BWD) || stop_hit;
    flip     = end_ph && (phase == PH_FWD);
`ifdef RENJU_EXACT_EN
    won      = (ev_cnt == WIN_C);
`else
    won      = (ev_cnt >= WIN_C);
`endif
  end

  // Scan FSM: later assignments (phase flip, direction evaluation) override the per-state defaults
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      phase   <= PH_FWD;
      dir     <= DIR_H;
      mx      <= '0;
      my      <= '0;
      cx      <= '0;
      cy      <= '0;
      color   <= C_EMPTY;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      winner  <= C_EMPTY;
      win_dir <= DIR_H;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mx      <= move_x;
            my      <= move_y;
            cx      <= move_x;
            cy      <= move_y;
            color   <= move_color;
            count   <= CW'(1);
            dir     <= DIR_H;
            phase   <= PH_FWD;
            winner  <= C_EMPTY;
            win_dir <= DIR_H;
            if (move_color == C_P1 || move_color == C_P2) begin
              state <= S_ISSUE;
              busy  <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (inb) begin
            cx    <= nx;
            cy    <= ny;
            state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (match) begin
            count <= cnt_nxt;
            if (!stop_hit) state <= S_ISSUE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (flip) begin
        phase <= PH_BWD;
        cx    <= mx;
        cy    <= my;
        state <= S_ISSUE;
      end

      if (eval_dir) begin
        if (won) begin
          winner  <= color;
          win_dir <= dir;
          state   <= S_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end else if (dir != DIR_A) begin
          dir   <= dir_t'(dir + 2'd1);
          count <= CW'(1);
          phase <= PH_FWD;
          cx    <= mx;
          cy    <= my;
          state <= S_ISSUE;
        end else begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_win_scanner.sv
// tb/tb_win_scanner.sv - randomized self-checking bench for win_scanner against a board-walk reference model
module tb_win_scanner;

  localparam int BW = 15;
  localparam int BH = 15;
  localparam int WL = 5;
  localparam int XW = $clog2(BW);
  localparam int YW = $clog2(BH);
  localparam int AW = $clog2(BW * BH);
`ifdef RENJU_EXACT_EN
  localparam bit EXACT = 1'b1;
`else
  localparam bit EXACT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn, start;
  logic [XW-1:0] move_x;
  logic [YW-1:0] move_y;
  logic [1:0]    move_color, rd_data, winner, win_dir;
  logic          rd_en, busy, done;
  logic [AW-1:0] rd_addr;

  logic [1:0] board [BW*BH];
  int dxs [4] = '{1, 0, 1, 1};
  int dys [4] = '{0, 1, 1, -1};
  int errors = 0;
  int checks = 0;
  int total_reads = 0;

  win_scanner #(.BOARD_W(BW), .BOARD_H(BH), .WIN_LEN(WL)) dut (
    .clk(clk), .resetn(resetn), .start(start), .move_x(move_x), .move_y(move_y),
    .move_color(move_color), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .winner(winner), .win_dir(win_dir)
  );

  always #5 clk = ~clk;

  // Board RAM: one-cycle read latency, garbage when not reading
  always @(posedge clk) begin
    if (rd_en === 1'b1 && int'(rd_addr) < BW * BH) rd_data <= board[rd_addr];
    else rd_data <= 2'($urandom);
  end

  always @(negedge clk) if (rd_en === 1'b1) total_reads <= total_reads + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model(input int x, input int y, input logic [1:0] c,
                                output logic [1:0] w, output logic [1:0] wd,
                                output int rds, output int cyc);
    int n, px, py, sgn, stop;
    bit hit;
    stop = EXACT ? WL + 1 : WL;
    w = 2'b00; wd = 2'b00; rds = 0; cyc = 0;
    if (c != 2'b01 && c != 2'b10) return;
    for (int d = 0; d < 4; d++) begin
      n = 1; hit = 1'b0;
      for (int ph = 0; ph < 2 && !hit; ph++) begin
        sgn = (ph == 0) ? 1 : -1;
        px = x; py = y;
        while (1'b1) begin
          px += sgn * dxs[d];
          py += sgn * dys[d];
          if (px < 0 || px >= BW || py < 0 || py >= BH) begin cyc += 1; break; end
          rds++; cyc += 2;
          if (board[py*BW+px] != c) break;
          n++;
          if (n == stop) begin hit = 1'b1; break; end
        end
      end
      if (EXACT ? (n == WL) : (n >= WL)) begin w = c; wd = 2'(d); return; end
    end
  endfunction

  task automatic clear_board();
    for (int i = 0; i < BW*BH; i++) board[i] = 2'b00;
  endtask

  task automatic do_move(input int x, input int y, input logic [1:0] c,
                         output logic [1:0] gw, output logic [1:0] gd,
                         output int lat, output int rds, output bit bok, output bit dok);
    int r0;
    @(negedge clk);
    r0 = total_reads;
    move_x = XW'(x); move_y = YW'(y); move_color = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1; bok = 1'b1;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1) bok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b0) bok = 1'b0;
    gw = winner; gd = win_dir; rds = total_reads - r0;
    @(negedge clk);
    dok = (done === 1'b0) && (winner === gw);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    checks++;
    if ({rd_en, busy, done, winner, win_dir} !== 7'b0 || rd_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd_en=%b busy=%b done=%b winner=%b win_dir=%b rd_addr=%0d expected all zero",
               rd_en, busy, done, winner, win_dir, rd_addr);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_en, busy, done} !== 3'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got rd_en=%b busy=%b done=%b expected 000", rd_en, busy, done);
    end
  endtask

  task automatic test_empty_center();
    logic [1:0] gw, gd; int lat, rds; bit bok, dok;
    clear_board();
    do_move(7, 7, 2'b01, gw, gd, lat, rds, bok, dok);
    checks++; if (gw !== 2'b00) begin errors++; $display("FAIL empty_winner: got %0d expected 0", gw); end
    checks++; if (lat != 17) begin errors++; $display("FAIL empty_latency: got %0d expected 17", lat); end
    checks++; if (rds != 8) begin errors++; $display("FAIL empty_reads: got %0d expected 8", rds); end
    checks++; if (!bok || !dok) begin errors++; $display("FAIL empty_busy_done: got busy_ok=%0d done_ok=%0d expected 1 1", bok, dok); end
  endtask

  task automatic test_horizontal();
    logic [1:0] gw, gd, ew, ed; int lat, rds, erd, ecyc; bit bok, dok;
    clear_board();
    for (int x = 3; x <= 7; x++) board[4*BW+x] = 2'b01;
    model(5, 4, 2'b01, ew, ed, erd, ecyc);
    do_move(5, 4, 2'b01, gw, gd, lat, rds, bok, dok);
    checks++; if (gw !== 2'b01 || gd !== 2'd0) begin errors++; $display("FAIL horiz_result: got winner=%0d dir=%0d expected 1 0", gw, gd); end
    checks++; if (rds != erd) begin errors++; $display("FAIL horiz_reads: got %0d expected %0d", rds, erd); end
    checks++; if (lat != ecyc + 1) begin errors++; $display("FAIL horiz_latency: got %0d expected %0d", lat, ecyc + 1); end
  endtask

  task automatic test_anti_corner();
    logic [1:0] gw, gd, ew, ed; int lat, rds, erd, ecyc; bit bok, dok;
    clear_board();
    for (int k = 0; k < 5; k++) board[(14-k)*BW+k] = 2'b10;
    model(0, 14, 2'b10, ew, ed, erd, ecyc);
    do_move(0, 14, 2'b10, gw, gd, lat, rds, bok, dok);
    checks++; if (gw !== 2'b10 || gd !== 2'd3) begin errors++; $display("FAIL corner_result: got winner=%0d dir=%0d expected 2 3", gw, gd); end
    checks++; if (rds != erd) begin errors++; $display("FAIL corner_reads: got %0d expected %0d", rds, erd); end
    checks++; if (lat != ecyc + 1) begin errors++; $display("FAIL corner_latency: got %0d expected %0d", lat, ecyc + 1); end
  endtask

  task automatic test_column_overline();
    logic [1:0] gw, gd, ew, ed, xw; int lat, rds, erd, ecyc; bit bok, dok;
    clear_board();
    for (int y = 2; y <= 7; y++) board[y*BW+9] = 2'b01;
    xw = EXACT ? 2'b00 : 2'b01;
    model(9, 5, 2'b01, ew, ed, erd, ecyc);
    do_move(9, 5, 2'b01, gw, gd, lat, rds, bok, dok);
    checks++; if (gw !== xw) begin errors++; $display("FAIL column_winner: got %0d expected %0d", gw, xw); end
    if (!EXACT) begin
      checks++; if (gd !== 2'd1) begin errors++; $display("FAIL column_dir: got %0d expected 1", gd); end
    end
    checks++; if (rds != erd || lat != ecyc + 1) begin errors++; $display("FAIL column_timing: got reads=%0d lat=%0d expected %0d %0d", rds, lat, erd, ecyc + 1); end
  endtask

  task automatic test_bad_color();
    logic [1:0] gw, gd; int lat, rds; bit bok, dok;
    logic [1:0] cols [2] = '{2'b00, 2'b11};
    clear_board();
    board[7*BW+8] = 2'b11;
    for (int i = 0; i < 2; i++) begin
      do_move(7, 7, cols[i], gw, gd, lat, rds, bok, dok);
      checks++;
      if (gw !== 2'b00 || lat != 1 || rds != 0 || !bok || !dok) begin
        errors++;
        $display("FAIL bad_color_%0d: got winner=%0d lat=%0d reads=%0d busy_ok=%0d expected 0 1 0 1", cols[i], gw, lat, rds, bok);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] ew, ed; int erd, ecyc, lat; bit saw_done;
    clear_board();
    @(negedge clk);
    move_x = 4'd7; move_y = 4'd7; move_color = 2'b01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if ({rd_en, busy, done} !== 3'b0 || rd_addr !== '0 || winner !== 2'b00) begin
      errors++;
      $display("FAIL midreset_outputs: got rd_en=%b busy=%b done=%b rd_addr=%0d expected all zero", rd_en, busy, done, rd_addr);
    end
    saw_done = 1'b0;
    repeat (3) begin @(negedge clk); if (done !== 1'b0) saw_done = 1'b1; end
    resetn = 1'b1;
    repeat (20) begin @(negedge clk); if (done !== 1'b0) saw_done = 1'b1; end
    checks++; if (saw_done) begin errors++; $display("FAIL midreset_no_done: got done pulse expected none"); end
    for (int x = 3; x <= 7; x++) board[4*BW+x] = 2'b01;
    model(5, 4, 2'b01, ew, ed, erd, ecyc);
    move_x = 4'd5; move_y = 4'd4; move_color = 2'b01; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 1;
    repeat (2) begin @(negedge clk); lat++; end
    move_x = 4'd0; move_y = 4'd0; move_color = 2'b10; start = 1'b1;
    @(negedge clk); start = 1'b0; lat++;
    while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    checks++;
    if (winner !== 2'b01 || win_dir !== 2'd0 || lat != ecyc + 1) begin
      errors++;
      $display("FAIL busy_start_ignored: got winner=%0d dir=%0d lat=%0d expected 1 0 %0d", winner, win_dir, lat, ecyc + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0] gw, gd, ew, ed, c; int lat, rds, erd, ecyc, mx, my, d, len, o, px, py, r; bit bok, dok;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < BW*BH; i++) begin
        r = $urandom_range(0, 9);
        board[i] = (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : (r == 6) ? 2'b11 : 2'b00;
      end
      mx = $urandom_range(0, BW-1); my = $urandom_range(0, BH-1);
      r = $urandom_range(0, 9);
      c = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
      board[my*BW+mx] = c;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom_range(0, 3); len = $urandom_range(2, 7); o = $urandom_range(0, len-1);
        for (int k = 0; k < len; k++) begin
          px = mx + (k - o) * dxs[d]; py = my + (k - o) * dys[d];
          if (px >= 0 && px < BW && py >= 0 && py < BH) board[py*BW+px] = c;
        end
      end
      model(mx, my, c, ew, ed, erd, ecyc);
      do_move(mx, my, c, gw, gd, lat, rds, bok, dok);
      checks++;
      if (gw !== ew || (ew != 2'b00 && gd !== ed)) begin
        errors++;
        $display("FAIL rand%0d_result: got winner=%0d dir=%0d expected %0d %0d", it, gw, gd, ew, ed);
      end
      checks++;
      if (rds != erd || lat != ecyc + 1) begin
        errors++;
        $display("FAIL rand%0d_timing: got reads=%0d lat=%0d expected %0d %0d", it, rds, lat, erd, ecyc + 1);
      end
      checks++;
      if (!bok || !dok) begin
        errors++;
        $display("FAIL rand%0d_handshake: got busy_ok=%0d done_ok=%0d expected 1 1", it, bok, dok);
      end
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; move_x = '0; move_y = '0; move_color = 2'b00;
    clear_board();
    repeat (2) @(negedge clk);
    test_reset();
    test_empty_center();
    test_horizontal();
    test_anti_corner();
    test_column_overline();
    test_bad_color();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
